div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 integer divider implementing RV32M DIV/DIVU/REM/REMU.
- Sits between register file read ports and register file write port: consumes rd1/rd2 operand values, returns result plus destination index through a valid/ready writeback port that feeds a3/wd3/we3 via the writeback mux.
- One operation in flight; core stalls on busy_o.

Parameters:
- XLen, 32, operand/result width in bits
- NReg, 32, number of architectural registers
- NRegWidth, $clog2(NReg), localparam, width of destination index

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  request new operation; accepted only when ready_o=1
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- rs1_i  input  XLen  dividend (rd1 value)
- rs2_i  input  XLen  divisor (rd2 value)
- rd_i  input  NRegWidth  destination register index
- ready_o  output  1  unit can accept start_i this cycle
- busy_o  output  1  operation accepted and result not yet consumed
- wb_valid_o  output  1  result available
- wb_ready_i  input  1  writeback consumes result
- wb_addr_o  output  NRegWidth  destination index (to a3)
- wb_data_o  output  XLen  quotient or remainder (to wd3)

Behaviour:
- Reset (async, rst_ni=0): state IDLE; ready_o=1, busy_o=0, wb_valid_o=0, wb_addr_o=0, wb_data_o=0, internal counter/registers 0. Reset mid-operation aborts; no result emitted.
- States: IDLE, DIV, FIX, DONE.
- IDLE: ready_o=1. On start_i: latch op, rd, operands. If rs2_i==0 or signed overflow (signed op, rs1=0x8000_0000, rs2=all-ones), go directly to DONE with special result; else store |rs1|, |rs2| (magnitudes for signed ops, raw for unsigned), record result signs, counter=0, go DIV.
- DIV: one restoring-division step per cycle (shift remainder left, bring in next dividend MSB, subtract divisor if no borrow, shift quotient bit in). Counter increments; after XLen steps go FIX.
- FIX: negate quotient if signs of operands differ (signed ops); negate remainder if dividend negative (signed REM); select quotient or remainder per op; go DONE.
- DONE: wb_valid_o=1, wb_addr_o/wb_data_o stable until handshake. On wb_valid_o & wb_ready_i: if start_i also high, accept new op in same cycle (back-to-back, ready_o=wb_ready_i in DONE); else go IDLE.
- Latency: normal op, start accepted at edge E0, wb_valid_o high after edge E0+XLen+1 (XLen+2 cycles incl. FIX). Special cases: wb_valid_o high after E0 (1 cycle).
- Special results: divide by zero: DIV/DIVU quotient = all-ones, REM/REMU = dividend. Overflow: DIV = 0x8000_0000, REM = 0.
- busy_o = state != IDLE. start_i while busy (not DONE handshake) ignored, no side effects.
- rd_i=0 processed normally; register file discards write to x0.
- wb_valid_o never deasserts without wb_ready_i (except reset).

Test Plan:
- DIV rs1=20, rs2=0xFFFFFFFD (-3), rd=5 -> after 34 cycles wb_valid_o=1, wb_data_o=0xFFFFFFFA, wb_addr_o=5; REM same operands -> 0x00000002.
- REMU rs1=0xFFFFFFFF, rs2=16 -> 0x0000000F; DIVU same -> 0x0FFFFFFF.
- DIVU rs2=0 -> 0xFFFFFFFF one cycle after start; REM rs1=0x12345678, rs2=0 -> 0x12345678.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000 one cycle after start; REM -> 0x00000000.
- Backpressure: wb_ready_i=0 for 5 cycles in DONE -> wb_valid_o/wb_data_o/wb_addr_o stable; start_i pulses ignored; then wb_ready_i=1 with start_i=1 -> new op accepted, next result correct.
- rst_ni low at cycle 10 of a DIV -> immediately busy_o=0, wb_valid_o=0; after release, no stale result emitted.

Source files
------------

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
//            with a valid/ready writeback port towards the register file.
// Revision : 1.0  initial release
// ============================================================================
module div_unit #(
  parameter  int XLen      = 32,
  parameter  int NReg      = 32,
  localparam int NRegWidth = $clog2(NReg)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [XLen-1:0]      rs1_i,
  input  logic [XLen-1:0]      rs2_i,
  input  logic [NRegWidth-1:0] rd_i,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [NRegWidth-1:0] wb_addr_o,
  output logic [XLen-1:0]      wb_data_o
);

  localparam int              c_cnt_w   = $clog2(XLen);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(XLen - 1);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);
  localparam logic [XLen-1:0] c_min_neg = {1'b1, {(XLen-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [XLen-1:0]      r_dvd;    // dividend shifts out MSB-first, quotient shifts in at LSB
  logic [XLen-1:0]      r_dvs;
  logic [XLen-1:0]      r_rem;
  logic                 r_is_rem;
  logic                 r_neg_q;
  logic                 r_neg_r;

  logic                 w_signed;
  logic                 w_div_zero;
  logic                 w_ovf;
  logic                 w_neg_a;
  logic                 w_neg_b;
  logic [XLen-1:0]      w_abs_a;
  logic [XLen-1:0]      w_abs_b;
  logic [XLen-1:0]      w_special_data;
  logic                 w_accept;
  logic [XLen:0]        w_rem_shift;
  logic [XLen:0]        w_diff;
  logic                 w_qbit;
  logic [XLen-1:0]      w_rem_next;
  logic [XLen-1:0]      w_quot_fix;
  logic [XLen-1:0]      w_rem_fix;
  logic [XLen-1:0]      w_fix_data;

  // Operand decode for a request presented this cycle
  assign w_signed   = ~op_i[0];
  assign w_div_zero = (rs2_i == '0);
  assign w_ovf      = w_signed & (rs1_i == c_min_neg) & (&rs2_i);
  assign w_neg_a    = w_signed & rs1_i[XLen-1];
  assign w_neg_b    = w_signed & rs2_i[XLen-1];
  assign w_abs_a    = w_neg_a ? -rs1_i : rs1_i;
  assign w_abs_b    = w_neg_b ? -rs2_i : rs2_i;

  // Divide-by-zero wins over overflow; overflow cannot have a zero divisor anyway
  assign w_special_data = w_div_zero ? (op_i[1] ? rs1_i : {XLen{1'b1}})
                                     : (op_i[1] ? '0    : c_min_neg);

  assign ready_o    = (r_state == S_IDLE) | ((r_state == S_DONE) & wb_ready_i);
  assign busy_o     = (r_state != S_IDLE);
  assign wb_valid_o = (r_state == S_DONE);
  assign w_accept   = start_i & ready_o;

  // One restoring step: the extra top bit of w_diff is the borrow
  assign w_rem_shift = {r_rem, r_dvd[XLen-1]};
  assign w_diff      = w_rem_shift - {1'b0, r_dvs};
  assign w_qbit      = ~w_diff[XLen];
  assign w_rem_next  = w_qbit ? w_diff[XLen-1:0] : w_rem_shift[XLen-1:0];

  assign w_quot_fix  = r_neg_q ? -r_dvd : r_dvd;
  assign w_rem_fix   = r_neg_r ? -r_rem : r_rem;
  assign w_fix_data  = r_is_rem ? w_rem_fix : w_quot_fix;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_is_rem  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_is_rem  <= op_i[1];
            wb_addr_o <= rd_i;
            r_cnt     <= '0;
            if (w_div_zero | w_ovf) begin
              wb_data_o <= w_special_data;
              r_state   <= S_DONE;
            end else begin
              r_dvd   <= w_abs_a;
              r_dvs   <= w_abs_b;
              r_rem   <= '0;
              r_neg_q <= w_neg_a ^ w_neg_b;
              r_neg_r <= w_neg_a;
              r_state <= S_DIV;
            end
          end else if ((r_state == S_DONE) && wb_ready_i) begin
            r_state <= S_IDLE;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_dvd <= {r_dvd[XLen-2:0], w_qbit};
          r_cnt <= r_cnt + c_one;
          if (r_cnt == c_last) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          wb_data_o <= w_fix_data;
          r_state   <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Self-checking bench for div_unit: directed vectors, corner
//            sequences and randomized operations against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_div_unit;

  localparam int XLen      = 32;
  localparam int NReg      = 32;
  localparam int NRegWidth = 5;
  localparam int LatNormal = XLen + 2;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 start_i = 1'b0;
  logic [1:0]           op_i = 2'b00;
  logic [XLen-1:0]      rs1_i = '0;
  logic [XLen-1:0]      rs2_i = '0;
  logic [NRegWidth-1:0] rd_i = '0;
  logic                 ready_o;
  logic                 busy_o;
  logic                 wb_valid_o;
  logic                 wb_ready_i = 1'b0;
  logic [NRegWidth-1:0] wb_addr_o;
  logic [XLen-1:0]      wb_data_o;

  int checks   = 0;
  int failures = 0;

  div_unit #(.XLen(XLen), .NReg(NReg)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .op_i       (op_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .rd_i       (rd_i),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .wb_valid_o (wb_valid_o),
    .wb_ready_i (wb_ready_i),
    .wb_addr_o  (wb_addr_o),
    .wb_data_o  (wb_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Architectural RV32M result, straight from the ISA rules
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return LatNormal;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    rd_i    = rd;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  // Counts edges from the accepting edge until wb_valid_o; noise pokes start_i meanwhile
  task automatic wait_result(input bit noise, output logic [31:0] data,
                             output logic [4:0] addr, output int lat);
    lat = 1;
    while (!wb_valid_o && lat < 100) begin
      if (noise) begin
        start_i = 1'($urandom_range(0, 1));
        op_i    = 2'($urandom_range(0, 3));
        rs1_i   = $urandom;
        rs2_i   = $urandom;
        rd_i    = 5'($urandom_range(0, 31));
      end
      @(posedge clk_i);
      #1;
      lat++;
    end
    start_i = 1'b0;
    data    = wb_data_o;
    addr    = wb_addr_o;
  endtask

  task automatic consume();
    wb_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    wb_ready_i = 1'b0;
    chk("valid_after_consume", {31'd0, wb_valid_o}, 32'd0);
  endtask

  task automatic run_one(input string name, input bit noise, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int exp_lat);
    logic [31:0] d;
    logic [4:0]  ad;
    int          lat;
    issue(op, a, b, rd);
    wait_result(noise, d, ad, lat);
    chk({name, "_data"}, d, exp);
    chk({name, "_addr"}, {27'd0, ad}, {27'd0, rd});
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    consume();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[10];
    logic [31:0] d, d0;
    logic [4:0]  ad, ad0;
    int          lat;
    bit          seen;

    vecs[0] = '{2'b00, 32'd20,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFFA, LatNormal};
    vecs[1] = '{2'b10, 32'd20,         32'hFFFF_FFFD, 5'd6,  32'h0000_0002, LatNormal};
    vecs[2] = '{2'b11, 32'hFFFF_FFFF,  32'd16,        5'd7,  32'h0000_000F, LatNormal};
    vecs[3] = '{2'b01, 32'hFFFF_FFFF,  32'd16,        5'd0,  32'h0FFF_FFFF, LatNormal};
    vecs[4] = '{2'b01, 32'd1234,       32'd0,         5'd1,  32'hFFFF_FFFF, 1};
    vecs[5] = '{2'b10, 32'h1234_5678,  32'd0,         5'd2,  32'h1234_5678, 1};
    vecs[6] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 5'd3,  32'h8000_0000, 1};
    vecs[7] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 5'd4,  32'h0000_0000, 1};
    vecs[8] = '{2'b10, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, LatNormal};
    vecs[9] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF, 5'd31, 32'h0000_0000, LatNormal};

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_valid", {31'd0, wb_valid_o}, 32'd0);
    chk("rst_addr", {27'd0, wb_addr_o}, 32'd0);
    chk("rst_data", wb_data_o, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 10; i++) begin
      run_one($sformatf("vec%0d", i), 1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
              vecs[i].exp, vecs[i].lat);
    end

    // Busy flag while dividing
    issue(2'b00, 32'd1000, 32'd7, 5'd12);
    chk("busy_in_div", {30'd0, busy_o, ready_o}, 32'd2);
    wait_result(1'b1, d, ad, lat);
    chk("busy_div_data", d, 32'd142);
    consume();

    // Backpressure: result held, starts ignored, then back-to-back accept
    issue(2'b00, 32'd100, 32'd7, 5'd11);
    wait_result(1'b0, d0, ad0, lat);
    chk("bp_first_data", d0, 32'd14);
    for (int i = 0; i < 5; i++) begin
      start_i = 1'b1;
      op_i    = 2'($urandom_range(0, 3));
      rs1_i   = $urandom;
      rs2_i   = $urandom;
      rd_i    = 5'($urandom_range(0, 31));
      @(posedge clk_i);
      #1;
      chk("bp_valid", {31'd0, wb_valid_o}, 32'd1);
      chk("bp_data", wb_data_o, d0);
      chk("bp_addr", {27'd0, wb_addr_o}, 32'd11);
    end
    wb_ready_i = 1'b1;
    start_i    = 1'b1;
    op_i       = 2'b01;
    rs1_i      = 32'd1000;
    rs2_i      = 32'd10;
    rd_i       = 5'd9;
    @(posedge clk_i);
    #1;
    start_i    = 1'b0;
    wb_ready_i = 1'b0;
    chk("b2b_state", {30'd0, busy_o, wb_valid_o}, 32'd2);
    wait_result(1'b0, d, ad, lat);
    chk("b2b_data", d, 32'd100);
    chk("b2b_addr", {27'd0, ad}, 32'd9);
    chk("b2b_lat", 32'(lat), 32'(LatNormal));
    consume();

    // Reset mid-operation
    issue(2'b00, 32'd999, 32'd3, 5'd13);
    repeat (9) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_valid", {31'd0, wb_valid_o}, 32'd0);
    chk("midrst_ready", {31'd0, ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk_i);
      #1;
      if (wb_valid_o || busy_o) seen = 1'b1;
    end
    chk("midrst_no_stale", {31'd0, seen}, 32'd0);
    run_one("post_rst", 1'b0, 2'b11, 32'd999, 32'd10, 5'd14, 32'd9, LatNormal);

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      logic [4:0]  rd;
      int          sel;
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      rd  = 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = $urandom_range(1, 15);
      else if (sel == 3) b = -($urandom_range(1, 15));
      else if (sel == 4) a = $urandom_range(0, 20);
      run_one($sformatf("rnd%0d", i), 1'b1, op, a, b, rd, ref_div(op, a, b), ref_lat(op, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
